y86_alu: RTL and testbench
==========================

// Module: y86_alu
// PURPOSE
//  64-bit integer ALU for the Y86-64 execute stage (OPq: add/sub/and/xor).
//  Computes ans from operands a,b under a 2-bit control code and flags signed overflow.
//  Result, overflow, zero and sign are registered: 1-cycle latency, updated only when en=1.
//  The execute stage latches zf/sf/of into the condition codes for OPq instructions.
// PARAMETERS
//  W  64  operand/result width in bits (the only required value is 64)
// PORTS
//  clk       in   1   clock, rising edge
//  rst_n     in   1   asynchronous active-low reset
//  en        in   1   capture enable; outputs hold when 0
//  control   in   2   00=add 01=sub 10=and 11=xor
//  a         in   W   operand A, two's complement
//  b         in   W   operand B, two's complement
//  ans       out  W   registered result
//  overflow  out  1   registered signed overflow
//  zf        out  1   registered (ans==0)
//  sf        out  1   registered ans[W-1]
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low. While rst_n=0, ans=0, overflow=0, zf=0, sf=0.
//  - Release from reset is synchronous to clk.
//  - On a rising edge with rst_n=1 and en=1, the next-state values are computed from the current inputs.
//  - On a rising edge with en=0, all outputs hold their values.
//  - Results: add: ans=a+b mod 2^W. sub: ans=a-b mod 2^W, computed as a+~b+1.
//    and: ans=a&b. xor: ans=a^b.
//  - Overflow for add: a[W-1]==b[W-1] and ans[W-1]!=a[W-1].
//  - Overflow for sub: a[W-1]!=b[W-1] and ans[W-1]!=a[W-1].
//  - Overflow for and/xor: 0.
//  - Carry-out is discarded and is never an output.
//  - zf and sf are derived from the same next-state ans in the same edge as ans.
//  - Latency: inputs sampled at edge N appear on the outputs after edge N. There is no pipelining beyond that register.
//  - Reset asserted mid-operation clears the outputs immediately. The pending computation is lost.
//  - Boundaries:
//    - 0x7FFF..F + 1 -> 0x8000..0, of=1, sf=1.
//    - 0x8000..0 - 1 -> 0x7FFF..F, of=1, sf=0.
//    - 0xFFFF..F + 1 -> 0, zf=1, of=0.
//    - 0x8000..0 - 0x8000..0 -> 0, zf=1, of=0.
//  - No X propagation: every control value is defined, so there is no default/X branch.
// STRUCTURE
//  - Shared package y86_pkg: localparams ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_XOR=2'b11, and WORD_W=64.
//  - One sub-module: add_sub64, a ripple or carry-select adder built from 1-bit full adders.
//    - Inputs: a, b, sub. Outputs: sum, ovf.
//    - sub inverts b and sets carry-in=1.
//  - Bitwise and/xor and the result mux are in the top module; the output register is in the top module.
// TESTING
//  1. Reset: rst_n=0 with arbitrary inputs -> ans=0, overflow=0, zf=0, sf=0 immediately.
//     Outputs hold 0 until the first enabled edge after release.
//  2. Add: a=5, b=7, ctl=00, en=1 -> next edge ans=12, of=0, zf=0, sf=0.
//     a=0x7FFFFFFFFFFFFFFF, b=1 -> ans=0x8000000000000000, of=1, sf=1.
//  3. Sub: a=3, b=10, ctl=01 -> ans=0xFFFFFFFFFFFFFFF9 (-7), sf=1, of=0.
//     a=0x8000000000000000, b=1 -> ans=0x7FFFFFFFFFFFFFFF, of=1. a=b=42 -> ans=0, zf=1.
//  4. Logic: a=0xF0F0, b=0xFF00, ctl=10 -> ans=0xF000, of=0. Same operands with ctl=11 -> ans=0x0FF0, of=0.
//     a=b=0xFFFFFFFFFFFFFFFF, ctl=11 -> ans=0, zf=1.
//  5. Enable: load 5+7 (ans=12), then en=0 with a=1, b=1 for 3 cycles -> ans stays 12 and flags unchanged.
//  6. Mid-op reset: drive add with en=1, pulse rst_n low between edges -> outputs clear asynchronously.
//     The next enabled edge after release shows the new result.
//  7. Random: 10k random a/b/ctl vectors vs a reference model (a+b, a-b, &, ^, overflow rule) at 1-cycle latency.

Source files
------------

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
//   Shared definitions for the Y86-64 execute-stage ALU.
//   - WORD_W  : machine word width (64 for Y86-64)
//   - ALU_*   : 2-bit OPq control codes (add/sub/and/xor)
//   - fa_t / full_add : single-bit full adder used to build the ripple adder
// ---------------------------------------------------------------------------
package y86_pkg;

  localparam int WORD_W = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Sum and carry-out of one full-adder cell.
  typedef struct packed {
    logic sum;
    logic cout;
  } fa_t;

  // One-bit full adder: sum = x^y^cin, carry generated or propagated.
  function automatic fa_t full_add(input logic x, input logic y, input logic cin);
    fa_t r;
    r.sum  = x ^ y ^ cin;
    r.cout = (x & y) | (cin & (x ^ y));
    return r;
  endfunction

endpackage : y86_pkg

// File: rtl/y86_alu_add_sub64.sv
// ---------------------------------------------------------------------------
// add_sub64
//   Ripple-carry adder/subtractor built from 1-bit full adders.
//   Subtraction is a + ~b + 1: b is inverted and the carry-in is forced to 1.
//   The final carry-out is not exported; only the signed overflow is.
// Ports
//   a    in  W  operand A (two's complement)
//   b    in  W  operand B (two's complement)
//   sub  in  1  0 = a+b, 1 = a-b
//   sum  out W  result modulo 2^W
//   ovf  out 1  signed overflow of the selected operation
// ---------------------------------------------------------------------------
module add_sub64
  import y86_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] b_eff_s;

  // Operand B conditioning: one's complement for subtract.
  always_comb begin
    if (sub) begin
      b_eff_s = ~b;
    end else begin
      b_eff_s = b;
    end
  end

  // Ripple chain: the carry is a loop-local variable so the chain stays
  // a single combinational block instead of a self-referencing vector.
  always_comb begin
    logic carry_v;
    fa_t  fa_v;
    sum     = '0;
    carry_v = sub;
    for (int i = 0; i < W; i++) begin
      fa_v    = full_add(a[i], b_eff_s[i], carry_v);
      sum[i]  = fa_v.sum;
      carry_v = fa_v.cout;
    end
  end

  // Signed overflow: both effective addends share a sign and the result
  // sign differs. With b inverted for subtract this is exactly
  // "a and b signs differ and result sign differs from a".
  always_comb begin
    ovf = (a[W-1] == b_eff_s[W-1]) & (sum[W-1] != a[W-1]);
  end

endmodule : add_sub64

// File: rtl/y86_alu.sv
// ---------------------------------------------------------------------------
// y86_alu
//   64-bit integer ALU for the Y86-64 execute stage (OPq add/sub/and/xor).
//   Result and flags are registered with one cycle of latency and are only
//   updated on edges where en=1; otherwise they hold.
// Ports
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset (clears all outputs)
//   en        in   1  capture enable
//   control   in   2  00=add 01=sub 10=and 11=xor
//   a, b      in   W  operands, two's complement
//   ans       out  W  registered result
//   overflow  out  1  registered signed overflow (0 for and/xor)
//   zf        out  1  registered (ans == 0)
//   sf        out  1  registered ans[W-1]
// ---------------------------------------------------------------------------
module y86_alu
  import y86_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   control,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] ans,
  output logic         overflow,
  output logic         zf,
  output logic         sf
);

  logic         sub_s;
  logic [W-1:0] sum_s;
  logic         ovf_s;
  logic [W-1:0] result_s;
  logic         result_ovf_s;

  logic [W-1:0] ans_d,      ans_q;
  logic         overflow_d, overflow_q;
  logic         zf_d,       zf_q;
  logic         sf_d,       sf_q;

  // Adder mode select.
  always_comb begin
    sub_s = (control == ALU_SUB);
  end

  add_sub64 #(
    .W (W)
  ) u_add_sub (
    .a   (a),
    .b   (b),
    .sub (sub_s),
    .sum (sum_s),
    .ovf (ovf_s)
  );

  // Result mux. All four codes are legal; xor takes the last arm.
  always_comb begin
    result_s     = '0;
    result_ovf_s = 1'b0;
    case (control)
      ALU_ADD, ALU_SUB: begin
        result_s     = sum_s;
        result_ovf_s = ovf_s;
      end
      ALU_AND: begin
        result_s     = a & b;
        result_ovf_s = 1'b0;
      end
      default: begin
        result_s     = a ^ b;
        result_ovf_s = 1'b0;
      end
    endcase
  end

  // Next-state: capture new result and flags when enabled, else hold.
  // zf/sf come from the same next-state value as ans.
  always_comb begin
    if (en) begin
      ans_d      = result_s;
      overflow_d = result_ovf_s;
      zf_d       = (result_s == {W{1'b0}});
      sf_d       = result_s[W-1];
    end else begin
      ans_d      = ans_q;
      overflow_d = overflow_q;
      zf_d       = zf_q;
      sf_d       = sf_q;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans_q      <= '0;
      overflow_q <= 1'b0;
      zf_q       <= 1'b0;
      sf_q       <= 1'b0;
    end else begin
      ans_q      <= ans_d;
      overflow_q <= overflow_d;
      zf_q       <= zf_d;
      sf_q       <= sf_d;
    end
  end

  assign ans      = ans_q;
  assign overflow = overflow_q;
  assign zf       = zf_q;
  assign sf       = sf_q;

endmodule : y86_alu

// File: tb/tb_y86_alu.sv
module tb_y86_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  control;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] ans;
  logic        overflow;
  logic        zf;
  logic        sf;

  y86_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .control  (control),
    .a        (a),
    .b        (b),
    .ans      (ans),
    .overflow (overflow),
    .zf       (zf),
    .sf       (sf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] ans;
    logic        of;
    logic        zf;
    logic        sf;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // model of the architectural output state
  logic [63:0] m_ans;
  logic        m_of, m_zf, m_sf;

  // Reference: plain arithmetic; overflow = true signed result out of range.
  function automatic void ref_op(input logic [1:0] c, input logic [63:0] x, input logic [63:0] y,
                                 output logic [63:0] r, output logic o);
    logic signed [64:0] wide;
    logic signed [64:0] sx;
    logic signed [64:0] sy;
    sx = $signed({x[63], x});
    sy = $signed({y[63], y});
    r  = 64'd0;
    o  = 1'b0;
    case (c)
      2'b00: begin
        r    = x + y;
        wide = sx + sy;
        o    = (wide != $signed({r[63], r}));
      end
      2'b01: begin
        r    = x - y;
        wide = sx - sy;
        o    = (wide != $signed({r[63], r}));
      end
      2'b10: r = x & y;
      default: r = x ^ y;
    endcase
  endfunction

  task automatic compare(input string tag, input logic [63:0] ea, input logic eo,
                         input logic ez, input logic es);
    checks++;
    if (ans !== ea || overflow !== eo || zf !== ez || sf !== es) begin
      errors++;
      $display("FAIL %s: got ans=%h of=%b zf=%b sf=%b, expected ans=%h of=%b zf=%b sf=%b",
               tag, ans, overflow, zf, sf, ea, eo, ez, es);
    end
  endtask

  function automatic void push_model(input string tag);
    exp_t e;
    e.ans = m_ans;
    e.of  = m_of;
    e.zf  = m_zf;
    e.sf  = m_sf;
    e.tag = tag;
    sb_q.push_back(e);
  endfunction

  // Drive one cycle of stimulus and queue the state expected after the edge.
  task automatic step(input logic e, input logic [1:0] c, input logic [63:0] x,
                      input logic [63:0] y, input string tag);
    logic [63:0] r;
    logic        o;
    @(negedge clk);
    en      = e;
    control = c;
    a       = x;
    b       = y;
    if (e) begin
      ref_op(c, x, y, r, o);
      m_ans = r;
      m_of  = o;
      m_zf  = (r == 64'd0);
      m_sf  = r[63];
    end
    push_model(tag);
  endtask

  // Monitor: one expected entry per queued edge, checked 1 time unit after it.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      compare(e.tag, e.ans, e.of, e.zf, e.sf);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] pick_operand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'h7FFF_FFFF_FFFF_FFFF;
      1: v = 64'h8000_0000_0000_0000;
      2: v = 64'hFFFF_FFFF_FFFF_FFFF;
      3: v = 64'd0;
      4: v = 64'd1;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial begin
    // reset with arbitrary inputs
    rst_n   = 1'b0;
    en      = 1'b1;
    control = 2'b00;
    a       = 64'h1234_5678_9ABC_DEF0;
    b       = 64'h0FED_CBA9_8765_4321;
    m_ans   = 64'd0;
    m_of    = 1'b0;
    m_zf    = 1'b0;
    m_sf    = 1'b0;
    #1;
    compare("reset_immediate", 64'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    compare("reset_held", 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;

    step(1'b0, 2'b00, 64'd9, 64'd9, "post_reset_hold");
    step(1'b0, 2'b01, 64'd3, 64'd4, "post_reset_hold2");

    // directed cases
    step(1'b1, 2'b00, 64'd5, 64'd7, "add_5_7");
    step(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "add_max_pos_ovf");
    step(1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "add_wrap_zero");
    step(1'b1, 2'b01, 64'd3, 64'd10, "sub_neg7");
    step(1'b1, 2'b01, 64'h8000_0000_0000_0000, 64'd1, "sub_min_ovf");
    step(1'b1, 2'b01, 64'd42, 64'd42, "sub_equal");
    step(1'b1, 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "sub_min_min");
    step(1'b1, 2'b10, 64'hF0F0, 64'hFF00, "and_f0f0");
    step(1'b1, 2'b11, 64'hF0F0, 64'hFF00, "xor_f0f0");
    step(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "xor_all_ones");

    // enable hold
    step(1'b1, 2'b00, 64'd5, 64'd7, "en_load");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 64'd1, 64'd1, "en_hold");
    end

    // mid-operation reset pulse between edges
    @(negedge clk);
    en      = 1'b1;
    control = 2'b00;
    a       = 64'd100;
    b       = 64'd23;
    #2;
    rst_n = 1'b0;
    #1;
    compare("midop_reset_clear", 64'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    m_ans = 64'd123;
    m_of  = 1'b0;
    m_zf  = 1'b0;
    m_sf  = 1'b0;
    push_model("midop_after_release");

    // random vectors
    for (int i = 0; i < 10000; i++) begin
      logic        re;
      logic [1:0]  rc;
      logic [63:0] ra;
      logic [63:0] rb;
      re = ($urandom_range(0, 7) != 0);
      rc = 2'($urandom_range(0, 3));
      ra = pick_operand();
      rb = pick_operand();
      step(re, rc, ra, rb, "random");
    end

    // drain scoreboard with a bounded wait
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_y86_alu
